// File: rtl/byte_framer.sv
// ============================================================================
// Module   : byte_framer
// Purpose  : Link-layer framer: wraps payload in STP/SDP..END/EDB, emits IDL
//            when idle and inserts periodic COM+3xSKP ordered sets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_framer #(
  parameter int BITS         = 8,
  parameter int SKP_INTERVAL = 32
) (
  input  logic            CLK,
  input  logic            RESET_L,
  input  logic [BITS-1:0] IN_DATA,
  input  logic            IN_VALID,
  input  logic            IN_LAST,
  input  logic            IN_TYPE,
  input  logic            IN_ABORT,
  output logic            IN_READY,
  output logic [BITS-1:0] D,
  output logic            DK,
  output logic            ERR
);

  localparam logic [BITS-1:0] c_stp = 8'hFB;
  localparam logic [BITS-1:0] c_sdp = 8'h5C;
  localparam logic [BITS-1:0] c_end = 8'hFD;
  localparam logic [BITS-1:0] c_edb = 8'hFE;
  localparam logic [BITS-1:0] c_com = 8'hBC;
  localparam logic [BITS-1:0] c_skp = 8'h1C;
  localparam logic [BITS-1:0] c_idl = 8'h7C;

  localparam int CW = $clog2(SKP_INTERVAL + 1);
  localparam logic [CW-1:0] c_skp_max = CW'(SKP_INTERVAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SKPOS = 2'd1,
    S_DATA  = 2'd2,
    S_ENDP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sub;
  logic          r_abort;
  logic          w_pending;

  assign w_pending = (r_cnt == c_skp_max);
  assign IN_READY  = (r_state == S_DATA);

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sub   <= '0;
      r_abort <= 1'b0;
      D       <= c_idl;
      DK      <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      ERR <= 1'b0;
      // Saturating interval count; the COM branch below overrides with a clear.
      if (r_state != S_SKPOS && !w_pending)
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          DK <= 1'b0;
          if (w_pending) begin
            D       <= c_com;
            r_cnt   <= '0;
            r_sub   <= '0;
            r_state <= S_SKPOS;
          end else if (IN_VALID) begin
            D       <= IN_TYPE ? c_sdp : c_stp;
            r_state <= S_DATA;
          end else begin
            D <= c_idl;
          end
        end
        S_SKPOS: begin
          D     <= c_skp;
          DK    <= 1'b0;
          r_sub <= r_sub + 1'b1;
          if (r_sub == 2'd2)
            r_state <= S_IDLE;
        end
        S_DATA: begin
          if (IN_VALID) begin
            D  <= IN_DATA;
            DK <= 1'b1;
            if (IN_LAST) begin
              r_abort <= IN_ABORT;
              r_state <= S_ENDP;
            end
          end else begin
            // Source ran dry mid-packet: nullify it on the wire.
            D       <= c_edb;
            DK      <= 1'b0;
            ERR     <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_ENDP: begin
          D       <= r_abort ? c_edb : c_end;
          DK      <= 1'b0;
          r_abort <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          D       <= c_idl;
          DK      <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_byte_framer.sv
// ============================================================================
// Module   : tb_byte_framer
// Purpose  : Scoreboard bench for byte_framer (framing, SKP placement, reset).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_byte_framer;

  localparam int INTV = 8;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_VALID = 1'b0;
  logic       IN_LAST = 1'b0;
  logic       IN_TYPE = 1'b0;
  logic       IN_ABORT = 1'b0;
  logic       IN_READY;
  logic [7:0] D;
  logic       DK;
  logic       ERR;

  byte_framer #(.BITS(8), .SKP_INTERVAL(INTV)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_LAST(IN_LAST), .IN_TYPE(IN_TYPE), .IN_ABORT(IN_ABORT),
    .IN_READY(IN_READY), .D(D), .DK(DK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       dk;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] byte_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  int         tbc = 0;
  int         in_skp = 0;
  bit         in_pkt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: IDL and COM/SKP are checked against an interval model,
  // every other symbol is popped from the scoreboard.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (in_skp > 0) begin
        chk("skp_sym", {D, DK, ERR}, {8'h1C, 2'b00});
        chk("skp_rdy", IN_READY, 0);
        in_skp--;
      end else if (D == 8'hBC && DK == 1'b0) begin
        chk("com_due", tbc, INTV);
        chk("com_in_pkt", in_pkt, 0);
        chk("com_err", ERR, 0);
        chk("com_rdy", IN_READY, 0);
        tbc = 0;
        in_skp = 3;
      end else if (D == 8'h7C && DK == 1'b0 && !in_pkt) begin
        chk("idl_skp_late", (tbc == INTV), 0);
        chk("idl_err", ERR, 0);
        chk("idl_rdy", IN_READY, 0);
        if (tbc < INTV) tbc++;
      end else if (sb.size() == 0) begin
        chk("unexpected_sym", {D, DK, ERR}, {8'h7C, 2'b00});
        if (tbc < INTV) tbc++;
      end else begin
        mon_e = sb.pop_front();
        chk("sym", {D, DK, ERR}, {mon_e.d, mon_e.dk, mon_e.err});
        chk("rdy", IN_READY, mon_e.rdy);
        if (!mon_e.dk && (mon_e.d == 8'hFB || mon_e.d == 8'h5C)) begin
          chk("start_skp_late", (tbc == INTV), 0);
          in_pkt = 1'b1;
        end else if (!mon_e.dk) begin
          in_pkt = 1'b0;
        end
        if (tbc < INTV) tbc++;
      end
    end
  end

  task automatic xfer();
    int   n = 0;
    logic r = 1'b0;
    do begin
      @(negedge CLK);
      r = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!r && n < 200);
    chk("hs_ready", r, 1);
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic mid_reset();
    mon_en   = 1'b0;
    RESET_L  = 1'b0;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_ABORT = 1'b0;
    @(posedge CLK);
    #1;
    chk("mrst_D", D, 8'h7C);
    chk("mrst_DK", DK, 0);
    chk("mrst_rdy", IN_READY, 0);
    chk("mrst_err", ERR, 0);
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    sb.delete();
    in_pkt = 1'b0;
    in_skp = 0;
    tbc    = 0;
    @(negedge CLK);
    #1;
    mon_en = 1'b1;
  endtask

  // Sends byte_q as one packet; rst_at >= 0 asserts reset before that byte.
  task automatic send_pkt(input bit typ, input bit abort, input int rst_at);
    int len = byte_q.size();
    sb.push_back('{d: (typ ? 8'h5C : 8'hFB), dk: 1'b0, err: 1'b0, rdy: 1'b1});
    for (int i = 0; i < len; i++)
      sb.push_back('{d: byte_q[i], dk: 1'b1, err: 1'b0, rdy: (i != len - 1)});
    if (rst_at < 0)
      sb.push_back('{d: (abort ? 8'hFE : 8'hFD), dk: 1'b0, err: 1'b0, rdy: 1'b0});
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        mid_reset();
        byte_q.delete();
        return;
      end
      IN_VALID = 1'b1;
      IN_DATA  = byte_q[i];
      IN_TYPE  = (i == 0) ? typ : 1'($urandom);
      IN_LAST  = (i == len - 1);
      IN_ABORT = (i == len - 1) ? abort : 1'($urandom);
      xfer();
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_ABORT = 1'b0;
    byte_q.delete();
  endtask

  task automatic rand_bytes(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endtask

  initial begin
    repeat (5) begin
      @(negedge CLK);
      chk("rst_D", D, 8'h7C);
      chk("rst_DK", DK, 0);
      chk("rst_err", ERR, 0);
      chk("rst_rdy", IN_READY, 0);
    end
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    @(negedge CLK);
    #1;
    mon_en = 1'b1;
    idle(10);

    byte_q = '{8'h33, 8'hFF};
    send_pkt(1'b0, 1'b0, -1);
    idle(3);

    byte_q = '{8'h55, 8'h41};
    send_pkt(1'b1, 1'b1, -1);
    idle(2);

    // Underrun after a single accepted byte
    sb.push_back('{d: 8'hFB, dk: 1'b0, err: 1'b0, rdy: 1'b1});
    sb.push_back('{d: 8'h12, dk: 1'b1, err: 1'b0, rdy: 1'b1});
    sb.push_back('{d: 8'hFE, dk: 1'b0, err: 1'b1, rdy: 1'b0});
    IN_VALID = 1'b1; IN_DATA = 8'h12; IN_TYPE = 1'b0; IN_LAST = 1'b0; IN_ABORT = 1'b0;
    xfer();
    idle(4);

    rand_bytes(1);
    send_pkt(1'b0, 1'b0, -1);

    // Long packet forces a deferred SKP, then back-to-back packets
    rand_bytes(20);
    send_pkt(1'b0, 1'b0, -1);
    rand_bytes(3);
    send_pkt(1'b0, 1'b0, -1);
    rand_bytes(2);
    send_pkt(1'b1, 1'b0, -1);
    idle(3);

    rand_bytes(6);
    send_pkt(1'b0, 1'b0, 3);
    idle(5);

    rand_bytes(4);
    send_pkt(1'b1, 1'b0, -1);

    for (int k = 0; k < 200 && (sb.size() > 0 || in_skp > 0); k++) @(negedge CLK);
    chk("drain", sb.size(), 0);
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/byte_framer.md
Name: byte_framer

Overview:
- Link-layer framing stage that sits directly upstream of the byte-striping block and drives its D/DK inputs.
- Accepts payload bytes over a valid/ready handshake and wraps each packet in STP…END (TLP) or SDP…END (DLLP) framing.
- Emits IDL when the link is idle and terminates broken packets with EDB.
- Inserts a periodic COM+3×SKP ordered set between packets.

Parameters:
- BITS, 8, symbol width in bits (the block only supports 8).
- SKP_INTERVAL, 32, cycles between SKP ordered-set requests (minimum 8).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESET_L  input  1  reset; synchronous, active-low.
- IN_DATA  input  BITS  payload byte.
- IN_VALID  input  1  IN_DATA is valid.
- IN_LAST  input  1  IN_DATA is the final byte of the packet.
- IN_TYPE  input  1  sampled at packet start: 0 = TLP (STP), 1 = DLLP (SDP).
- IN_ABORT  input  1  qualified with IN_LAST: nullify the packet (EDB instead of END).
- IN_READY  output  1  byte accepted this cycle when IN_VALID & IN_READY.
- D  output  BITS  symbol to the striping block, registered.
- DK  output  1  1 = data byte, 0 = control symbol, registered.
- ERR  output  1  one-cycle pulse on underrun termination, registered.

Behaviour:
- Symbol codes: STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C (hex).
- Reset (RESET_L=0 at an edge):
  - Outputs: D=IDL, DK=0, ERR=0, IN_READY=0.
  - Internal: state=IDLE, SKP counter=0, abort flag=0.
  - Reset mid-packet abandons the packet silently; no END or EDB is emitted.
- IN_READY is combinational and equals (state==DATA). It is never asserted in IDLE, SKPOS or ENDP.
- Latency: an accepted byte appears on D with DK=1 at the next clock edge.
- SKP counter:
  - Increments every cycle the state is not SKPOS, saturating at SKP_INTERVAL.
  - pending = (counter == SKP_INTERVAL).
  - Cleared to 0 on the edge that emits COM.
- States:
  - IDLE:
    - If pending: emit COM (DK=0), go to SKPOS with sub-count=0. SKP has priority over a waiting IN_VALID.
    - Else if IN_VALID: emit STP (IN_TYPE=0) or SDP (IN_TYPE=1), DK=0, go to DATA. The byte is not consumed in this cycle.
    - Else: emit IDL, DK=0.
  - SKPOS:
    - Emit SKP, DK=0, increment sub-count.
    - After the 3rd SKP, return to IDLE.
    - The full ordered set is always COM,SKP,SKP,SKP on 4 consecutive cycles.
  - DATA:
    - IN_VALID=1: emit IN_DATA, DK=1. If IN_LAST, latch IN_ABORT into the abort flag and go to ENDP.
    - IN_VALID=0 (underrun): emit EDB, DK=0, pulse ERR=1 for one cycle, go to IDLE.
  - ENDP:
    - Emit END (abort flag=0) or EDB (abort flag=1), DK=0.
    - Clear the abort flag, go to IDLE.
- A pending SKP raised mid-packet is deferred. It is emitted on the first IDLE cycle after END/EDB, ahead of any queued packet.
- A single-byte packet (IN_LAST on the first byte) is legal: STP, byte, END.
- IN_ABORT without IN_LAST is ignored.
- Back-to-back packets are legal, so the minimum gap is zero IDL: END is followed directly by STP/SDP if IN_VALID is high and no SKP is pending.
- IN_TYPE, IN_LAST and IN_ABORT are don't-care when IN_VALID=0.

Test Plan:
- Reset with IN_VALID=0 for 5 cycles, then release -> D=7C and DK=0 every cycle, IN_READY=0, ERR=0.
- TLP with IN_TYPE=0, bytes 33,FF, LAST on FF -> D = FB,33,FF,FD with DK = 0,1,1,0, then 7C; IN_READY high exactly 2 cycles.
- DLLP with IN_TYPE=1, bytes 55,41, LAST+ABORT on 41 -> D = 5C,55,41,FE with DK = 0,1,1,0.
- Underrun: TLP byte 12 accepted, then IN_VALID=0 -> D = FB,12,FE, ERR=1 on the FE cycle only, then 7C.
- SKP_INTERVAL=8, continuous 20-byte TLP -> no BC inside the packet; FD is immediately followed by BC,1C,1C,1C, then FB of the next packet; counter restarts at BC.
- Assert RESET_L=0 during the DATA state of a 6-byte packet -> next edge D=7C, DK=0, IN_READY=0; no FD or FE is emitted.
